// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit register of JK cells sharing one clock.
// Modes: 00 per-bit JK array, 01 modulo-N up count, 10 modulo-N down
// count, 11 parallel load. q, qn and tc are all registered.
module jk_reg_bank #(
  parameter int unsigned  WIDTH     = 8,
  parameter logic [32:0]  MODULUS   = (33'd1 << WIDTH),
  parameter logic [31:0]  RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Largest value of the counting range; MODULUS is at most 2**WIDTH so
  // MODULUS-1 always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 33'd1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(0);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] qn_q;
  logic             tc_q;
  logic             tc_d;

  // Characteristic equation of a JK cell, applied bit-wise:
  // 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    jk_next = (jv & ~cur) | (~kv & cur);
  endfunction

  // Next-state selection for q and the terminal-count flag.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          q_d = jk_next(q_q, j, k);
        end
        MODE_UP: begin
          // Values at or above the range top (left by JK/load) wrap too.
          if (q_q >= MAX_VAL) begin
            q_d  = ZERO;
            tc_d = 1'b1;
          end else begin
            q_d  = q_q + ONE;
          end
        end
        MODE_DOWN: begin
          // Out-of-range values simply count down towards the range.
          if (q_q == ZERO) begin
            q_d  = MAX_VAL;
            tc_d = 1'b1;
          end else begin
            q_d  = q_q - ONE;
          end
        end
        MODE_LOAD: begin
          q_d = d;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end else begin
      q_d  = q_q;
      tc_d = 1'b0;
    end
  end

  // State register; reset overrides enable, mode and any pending wrap.
  // qn is kept as its own register loaded with the complement so it is
  // exactly ~q on every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= RST_VAL;
      qn_q <= ~RST_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      qn_q <= ~q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign qn = qn_q;
  assign tc = tc_q;

endmodule
